// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stall, taken-branch flush, MDU occupancy
// with watchdog, and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   id_rs1/id_rs2           source regs of the ID instruction
//   id_uses_rs1/rs2         ID instruction actually reads rs1/rs2
//   id_ex_rd                rd of the instruction in EX
//   id_ex_mem_read          EX instruction is a load
//   ex_mdu_op               EX instruction is an MDU op
//   ex_branch_taken         EX resolved a taken branch/jump
//   mdu_done                MDU result valid pulse
//   pc_en, if_id_en         front-end load enables
//   if_id_flush             IF/ID becomes NOP
//   id_ex_flush             ID/EX becomes NOP
//   ex_hold                 freeze EX, bubble into EX/MEM
//   mdu_go, mdu_err         MDU start pulse, watchdog abort pulse
//   busy                    MDU in flight
//   stall_cycles            saturating count of cycles with pc_en==0
module hazard_control_unit #(
  parameter int STALL_CNT_W = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             id_ex_rd,
  input  logic                   id_ex_mem_read,
  input  logic                   ex_mdu_op,
  input  logic                   ex_branch_taken,
  input  logic                   mdu_done,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_hold,
  output logic                   mdu_go,
  output logic                   mdu_err,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int WW = $clog2(MDU_TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   load_use;
  logic                   timeout;

  // x0 is hardwired zero, so a load targeting it never blocks a reader.
  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
    ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
     (id_uses_rs2 && (id_rs2 == id_ex_rd)));

  assign timeout = (wait_cnt_q == WW'(MDU_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    mdu_go      = 1'b0;
    mdu_err     = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_mdu_op) begin
          mdu_go     = 1'b1;
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          ex_hold    = 1'b1;
          wait_cnt_d = WW'(1);
          state_d    = MDU_BUSY;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MDU_BUSY: begin
        busy     = 1'b1;
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        if (mdu_done) begin
          state_d = RUN;
        end else if (timeout) begin
          // Abort: drop the stuck op by bubbling ID/EX.
          mdu_err     = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = RUN;
        end else begin
          ex_hold    = 1'b1;
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_hazard_control_unit;

  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic          id_ex_mem_read = 1'b0, ex_mdu_op = 1'b0;
  logic          ex_branch_taken = 1'b0, mdu_done = 1'b0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic          ex_hold, mdu_go, mdu_err, busy;
  logic [SW-1:0] stall_cycles;

  hazard_control_unit #(.STALL_CNT_W(SW), .MDU_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_mdu_op(ex_mdu_op), .ex_branch_taken(ex_branch_taken),
    .mdu_done(mdu_done),
    .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_hold(ex_hold), .mdu_go(mdu_go), .mdu_err(mdu_err),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: whether an MDU op is outstanding, cycles since its
  // start pulse, and the number of front-end stall cycles so far.
  bit m_busy;
  int m_age;
  int m_stalls;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit lu_f();
    if (!id_ex_mem_read || id_ex_rd == 0) return 0;
    if (id_uses_rs1 && id_rs1 == id_ex_rd) return 1;
    if (id_uses_rs2 && id_rs2 == id_ex_rd) return 1;
    return 0;
  endfunction

  // Expected {pc_en,if_id_en,if_id_flush,id_ex_flush,ex_hold,mdu_go,mdu_err,busy}
  function automatic logic [7:0] exp_f();
    if (m_busy) begin
      if (mdu_done) return 8'b0000_0001;
      if (m_age == TO - 1) return 8'b0001_0011;
      return 8'b0000_1001;
    end
    if (ex_branch_taken) return 8'b1111_0000;
    if (ex_mdu_op) return 8'b0000_1100;
    if (lu_f()) return 8'b0001_0000;
    return 8'b1100_0000;
  endfunction

  function automatic logic [7:0] act_f();
    return {pc_en, if_id_en, if_id_flush, id_ex_flush,
            ex_hold, mdu_go, mdu_err, busy};
  endfunction

  logic [7:0] o;

  // One clock: inputs already applied; compare at negedge, update the
  // model at the following rising edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    e = exp_f();
    o = act_f();
    chk("ctl", int'(o), int'(e));
    chk("stall_cycles", int'(stall_cycles), m_stalls);
    @(posedge clk);
    if (!e[7] && m_stalls < (1 << SW) - 1) m_stalls++;
    if (m_busy) begin
      if (mdu_done || m_age == TO - 1) m_busy = 0;
      else m_age++;
    end else if (!ex_branch_taken && ex_mdu_op) begin
      m_busy = 1;
      m_age = 1;
    end
    #1;
  endtask

  task automatic drv(input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2,
                     input logic [4:0] rd, input logic mr,
                     input logic mo, input logic bt, input logic dn);
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_ex_rd = rd; id_ex_mem_read = mr; ex_mdu_op = mo;
    ex_branch_taken = bt; mdu_done = dn;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    m_busy = 0; m_age = 0; m_stalls = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int lows, busies, gos, errat;

  initial begin
    do_reset();

    // Reset state with idle inputs.
    @(negedge clk);
    chk("reset_ctl", int'(act_f()), 8'hC0);
    chk("reset_stall", int'(stall_cycles), 0);
    @(posedge clk); #1;

    // Load x5, add x6,x5,x1: one bubble.
    drv(5, 1, 1, 1, 5, 1, 0, 0, 0); step();
    chk("lu_pc_en", int'(o[7]), 0);
    chk("lu_flush", int'(o[4]), 1);
    idle(); step();
    chk("lu_stall_cnt", int'(stall_cycles), 1);

    // x0 load, and unused rs2 match: no stall.
    drv(0, 0, 1, 1, 0, 1, 0, 0, 0); step();
    chk("x0_pc_en", int'(o[7]), 1);
    drv(1, 5, 1, 0, 5, 1, 0, 0, 0); step();
    chk("rs2_unused_pc_en", int'(o[7]), 1);

    // Branch wins over load-use.
    drv(5, 5, 1, 1, 5, 1, 0, 1, 0); step();
    chk("br_ctl", int'(o), 8'hF0);
    idle(); step();
    chk("br_stall_cnt", int'(stall_cycles), 1);

    // MDU with done on the fifth cycle from go.
    lows = 0; busies = 0; gos = 0;
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 0, (i == 4));
      step();
      lows += int'(!o[7]); busies += int'(o[0]); gos += int'(o[2]);
      if (i == 4) chk("done_hold", int'(o[3]), 0);
    end
    chk("mdu_lows", lows, 5);
    chk("mdu_busy", busies, 4);
    chk("mdu_go_cnt", gos, 1);
    idle(); step();
    chk("mdu_back_run", int'(o[7]), 1);

    // Watchdog: err 7 cycles after go, then RUN.
    errat = -1;
    for (int i = 0; i < TO; i++) begin
      drv(0, 0, 0, 0, 0, 0, (i == 0), 0, 0);
      step();
      if (o[1]) errat = i;
      if (i == TO - 1) chk("err_flush", int'(o[4]), 1);
    end
    chk("err_cycle", errat, 7);
    idle(); step();
    chk("after_err_pc_en", int'(o[7]), 1);

    // Async reset in the middle of an MDU op.
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    idle(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(mdu_err), 0);
    chk("rst_stall", int'(stall_cycles), 0);
    m_busy = 0; m_age = 0; m_stalls = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Saturation: 20 load-use stalls into a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drv(7, 0, 1, 0, 7, 1, 0, 0, 0); step();
    end
    idle(); step();
    chk("sat", int'(stall_cycles), 15);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
          1'($urandom), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
